// File: rtl/stoch_signed_pool2d.sv
// Stochastic signed 2-D max/average pooling over bipolar (p/m split) bitstreams.
// Latency: 1 cycle from an en sample to registered y_p/y_m; y_valid is en delayed by one cycle.
// Backpressure: none; one sample per cycle, en=0 freezes window state and zeroes the outputs.
module stoch_signed_pool2d #(
  parameter int IM_HEIGHT    = 4,
  parameter int IM_WIDTH     = 4,
  parameter int CHANNELS     = 1,
  parameter int KERNEL_H     = 2,
  parameter int KERNEL_W     = 2,
  parameter int STRIDE_H     = 2,
  parameter int STRIDE_W     = 2,
  parameter int PAD_H        = 0,
  parameter int PAD_W        = 0,
  parameter int COUNTER_SIZE = 8,
  parameter int MODE         = 0,
  localparam int OUT_H = (IM_HEIGHT + 2*PAD_H - KERNEL_H) / STRIDE_H + 1,
  localparam int OUT_W = (IM_WIDTH  + 2*PAD_W - KERNEL_W) / STRIDE_W + 1
) (
  input  logic                                  CLK,
  input  logic                                  RST,
  input  logic                                  en,
  input  logic                                  clr,
  input  logic [CHANNELS*IM_HEIGHT*IM_WIDTH-1:0] x_p,
  input  logic [CHANNELS*IM_HEIGHT*IM_WIDTH-1:0] x_m,
  output logic [CHANNELS*OUT_H*OUT_W-1:0]        y_p,
  output logic [CHANNELS*OUT_H*OUT_W-1:0]        y_m,
  output logic                                  y_valid
);

  localparam int K  = KERNEL_H * KERNEL_W;
  localparam int SW = (K > 1) ? $clog2(K) : 1;

  // y_valid marks a cycle whose y_p/y_m came from an accepted sample
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)      y_valid <= 1'b0;
    else if (clr) y_valid <= 1'b0;
    else          y_valid <= en;
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    for (genvar oh = 0; oh < OUT_H; oh++) begin : g_oh
      for (genvar ow = 0; ow < OUT_W; ow++) begin : g_ow
        localparam int OI = c*OUT_H*OUT_W + ow*OUT_H + oh;

        // Window bits gathered in element order i = kw*KERNEL_H + kh
        logic [K-1:0] wp;
        logic [K-1:0] wm;

        for (genvar kw = 0; kw < KERNEL_W; kw++) begin : g_kw
          for (genvar kh = 0; kh < KERNEL_H; kh++) begin : g_kh
            localparam int PH = oh*STRIDE_H + kh - PAD_H;
            localparam int PW = ow*STRIDE_W + kw - PAD_W;
            localparam int EI = kw*KERNEL_H + kh;
            if (PH >= 0 && PH < IM_HEIGHT && PW >= 0 && PW < IM_WIDTH) begin : g_in
              localparam int XI = c*IM_HEIGHT*IM_WIDTH + PW*IM_HEIGHT + PH;
              assign wp[EI] = x_p[XI];
              assign wm[EI] = x_m[XI];
            end else begin : g_pad
              // Padding reads as a neutral (zero) sample
              assign wp[EI] = 1'b0;
              assign wm[EI] = 1'b0;
            end
          end
        end

        if (MODE == 0) begin : g_max
          localparam logic signed [COUNTER_SIZE-1:0] CMAX = {1'b0, {(COUNTER_SIZE-1){1'b1}}};
          localparam logic signed [COUNTER_SIZE-1:0] CMIN = -CMAX;
          localparam logic signed [COUNTER_SIZE-1:0] ONE  = COUNTER_SIZE'(1);

          logic signed [COUNTER_SIZE-1:0] cnt     [K];
          logic signed [COUNTER_SIZE-1:0] cnt_nxt [K];
          logic signed [COUNTER_SIZE-1:0] best;
          logic [SW-1:0]                  sel;
          logic                           yp_q;
          logic                           ym_q;

          // Argmax of the pre-update counters; strict compare keeps the lowest index on ties
          always_comb begin
            sel  = '0;
            best = cnt[0];
            for (int i = 1; i < K; i++) begin
              if (cnt[i] > best) begin
                best = cnt[i];
                sel  = SW'(i);
              end
            end
          end

          // Saturating +/-1 step per element; x_p=x_m=1 is a zero step
          always_comb begin
            for (int i = 0; i < K; i++) begin
              cnt_nxt[i] = cnt[i];
              if (wp[i] && !wm[i] && cnt[i] != CMAX)      cnt_nxt[i] = cnt[i] + ONE;
              else if (wm[i] && !wp[i] && cnt[i] != CMIN) cnt_nxt[i] = cnt[i] - ONE;
            end
          end

          // Forward the selected element's bits and advance the counters on each sample
          always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
              for (int i = 0; i < K; i++) cnt[i] <= '0;
              yp_q <= 1'b0;
              ym_q <= 1'b0;
            end else if (clr) begin
              for (int i = 0; i < K; i++) cnt[i] <= '0;
              yp_q <= 1'b0;
              ym_q <= 1'b0;
            end else if (en) begin
              for (int i = 0; i < K; i++) cnt[i] <= cnt_nxt[i];
              yp_q <= wp[sel];
              ym_q <= wm[sel];
            end else begin
              yp_q <= 1'b0;
              ym_q <= 1'b0;
            end
          end

          assign y_p[OI] = yp_q;
          assign y_m[OI] = ym_q;
        end else begin : g_avg
          // One spare bit over |acc| < K, plus the sign bit; the sum a needs one more
          localparam int AW = $clog2(K) + 2;
          localparam logic signed [AW:0] KS  = (AW+1)'(K);
          localparam logic signed [AW:0] ONE = (AW+1)'(1);

          logic signed [AW-1:0] acc;
          logic signed [AW-1:0] acc_nxt;
          logic signed [AW:0]   s;
          logic signed [AW:0]   a;
          logic signed [AW:0]   a_adj;
          logic                 hi;
          logic                 lo;
          logic                 yp_q;
          logic                 ym_q;

          // Sum the window, emit a +/- pulse whenever a full K has accumulated
          always_comb begin
            s = '0;
            for (int i = 0; i < K; i++) begin
              if (wp[i] && !wm[i])      s = s + ONE;
              else if (wm[i] && !wp[i]) s = s - ONE;
            end
            a     = {acc[AW-1], acc} + s;
            hi    = (a >= KS);
            lo    = (a <= -KS);
            a_adj = a;
            if (hi)      a_adj = a - KS;
            else if (lo) a_adj = a + KS;
            acc_nxt = AW'(a_adj);
          end

          // Accumulator and registered pulse outputs
          always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
              acc  <= '0;
              yp_q <= 1'b0;
              ym_q <= 1'b0;
            end else if (clr) begin
              acc  <= '0;
              yp_q <= 1'b0;
              ym_q <= 1'b0;
            end else if (en) begin
              acc  <= acc_nxt;
              yp_q <= hi;
              ym_q <= lo;
            end else begin
              yp_q <= 1'b0;
              ym_q <= 1'b0;
            end
          end

          assign y_p[OI] = yp_q;
          assign y_m[OI] = ym_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_stoch_signed_pool2d.sv
// Bench for stoch_signed_pool2d: max (A) and average (B) on a 4x4 image, padded average (C) on 2x2.
// Reference model works on (h,w) image arrays with plain integer counters and accumulators.
// Directed test-plan steps followed by randomized traffic and a mid-stream reset.
module tb_stoch_signed_pool2d;

  logic CLK = 1'b0;
  logic RST, en, clr;
  logic [15:0] xab_p, xab_m;
  logic [3:0]  xc_p, xc_m;
  logic [3:0]  ya_p, ya_m, yb_p, yb_m;
  logic [8:0]  yc_p, yc_m;
  logic        va, vb, vc;

  int checks = 0;
  int errors = 0;

  // Images indexed [h][w]; model state per output window
  int pa [4][4];
  int ma [4][4];
  int pc [2][2];
  int mc [2][2];
  int cnt_a [4][4];
  int acc_b [4];
  int acc_c [9];

  always #5 CLK = ~CLK;

  stoch_signed_pool2d #(.IM_HEIGHT(4), .IM_WIDTH(4), .CHANNELS(1), .KERNEL_H(2), .KERNEL_W(2),
    .STRIDE_H(2), .STRIDE_W(2), .PAD_H(0), .PAD_W(0), .COUNTER_SIZE(4), .MODE(0)) dut_a (
    .CLK(CLK), .RST(RST), .en(en), .clr(clr), .x_p(xab_p), .x_m(xab_m),
    .y_p(ya_p), .y_m(ya_m), .y_valid(va));

  stoch_signed_pool2d #(.IM_HEIGHT(4), .IM_WIDTH(4), .CHANNELS(1), .KERNEL_H(2), .KERNEL_W(2),
    .STRIDE_H(2), .STRIDE_W(2), .PAD_H(0), .PAD_W(0), .COUNTER_SIZE(8), .MODE(1)) dut_b (
    .CLK(CLK), .RST(RST), .en(en), .clr(clr), .x_p(xab_p), .x_m(xab_m),
    .y_p(yb_p), .y_m(yb_m), .y_valid(vb));

  stoch_signed_pool2d #(.IM_HEIGHT(2), .IM_WIDTH(2), .CHANNELS(1), .KERNEL_H(2), .KERNEL_W(2),
    .STRIDE_H(1), .STRIDE_W(1), .PAD_H(1), .PAD_W(1), .COUNTER_SIZE(8), .MODE(1)) dut_c (
    .CLK(CLK), .RST(RST), .en(en), .clr(clr), .x_p(xc_p), .x_m(xc_m),
    .y_p(yc_p), .y_m(yc_m), .y_valid(vc));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_images();
    for (int h = 0; h < 4; h++) for (int w = 0; w < 4; w++) begin pa[h][w] = 0; ma[h][w] = 0; end
    for (int h = 0; h < 2; h++) for (int w = 0; w < 2; w++) begin pc[h][w] = 0; mc[h][w] = 0; end
  endtask

  task automatic random_images();
    for (int h = 0; h < 4; h++) for (int w = 0; w < 4; w++) begin
      pa[h][w] = int'($urandom_range(0, 1)); ma[h][w] = int'($urandom_range(0, 1));
    end
    for (int h = 0; h < 2; h++) for (int w = 0; w < 2; w++) begin
      pc[h][w] = int'($urandom_range(0, 1)); mc[h][w] = int'($urandom_range(0, 1));
    end
  endtask

  task automatic drive_x();
    for (int h = 0; h < 4; h++) for (int w = 0; w < 4; w++) begin
      xab_p[w*4+h] = (pa[h][w] != 0);
      xab_m[w*4+h] = (ma[h][w] != 0);
    end
    for (int h = 0; h < 2; h++) for (int w = 0; w < 2; w++) begin
      xc_p[w*2+h] = (pc[h][w] != 0);
      xc_m[w*2+h] = (mc[h][w] != 0);
    end
  endtask

  task automatic model_reset();
    for (int o = 0; o < 4; o++) begin
      acc_b[o] = 0;
      for (int i = 0; i < 4; i++) cnt_a[o][i] = 0;
    end
    for (int o = 0; o < 9; o++) acc_c[o] = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_a"}, 32'({ya_p, ya_m, va}), 32'd0);
    check({tag, "_b"}, 32'({yb_p, yb_m, vb}), 32'd0);
    check({tag, "_c"}, 32'({yc_p, yc_m, vc}), 32'd0);
  endtask

  // Apply one cycle of (en, clr) with the current images, predict, then compare after the edge
  task automatic step(input bit e, input bit c);
    logic [3:0] ea_p, ea_m, eb_p, eb_m;
    logic [8:0] ec_p, ec_m;
    ea_p = '0; ea_m = '0; eb_p = '0; eb_m = '0; ec_p = '0; ec_m = '0;
    drive_x();
    en  = e;
    clr = c;
    if (c) begin
      model_reset();
    end else if (e) begin
      for (int oh = 0; oh < 2; oh++) for (int ow = 0; ow < 2; ow++) begin
        int oi, sel, s, a, h, w, d;
        oi  = ow*2 + oh;
        sel = 0;
        for (int i = 1; i < 4; i++) if (cnt_a[oi][i] > cnt_a[oi][sel]) sel = i;
        ea_p[oi] = (pa[oh*2 + sel%2][ow*2 + sel/2] != 0);
        ea_m[oi] = (ma[oh*2 + sel%2][ow*2 + sel/2] != 0);
        s = 0;
        for (int i = 0; i < 4; i++) begin
          h = oh*2 + i%2;
          w = ow*2 + i/2;
          d = pa[h][w] - ma[h][w];
          s += d;
          cnt_a[oi][i] += d;
          if (cnt_a[oi][i] > 7)  cnt_a[oi][i] = 7;
          if (cnt_a[oi][i] < -7) cnt_a[oi][i] = -7;
        end
        a = acc_b[oi] + s;
        if (a >= 4)       begin eb_p[oi] = 1'b1; a -= 4; end
        else if (a <= -4) begin eb_m[oi] = 1'b1; a += 4; end
        acc_b[oi] = a;
      end
      for (int oh = 0; oh < 3; oh++) for (int ow = 0; ow < 3; ow++) begin
        int oi, s, a, h, w;
        oi = ow*3 + oh;
        s  = 0;
        for (int i = 0; i < 4; i++) begin
          h = oh + i%2 - 1;
          w = ow + i/2 - 1;
          if (h >= 0 && h < 2 && w >= 0 && w < 2) s += pc[h][w] - mc[h][w];
        end
        a = acc_c[oi] + s;
        if (a >= 4)       begin ec_p[oi] = 1'b1; a -= 4; end
        else if (a <= -4) begin ec_m[oi] = 1'b1; a += 4; end
        acc_c[oi] = a;
      end
    end
    @(posedge CLK);
    #1;
    check("a_yp", 32'(ya_p), 32'(ea_p));
    check("a_ym", 32'(ya_m), 32'(ea_m));
    check("a_vld", 32'(va), 32'(e && !c));
    check("b_yp", 32'(yb_p), 32'(eb_p));
    check("b_ym", 32'(yb_m), 32'(eb_m));
    check("b_vld", 32'(vb), 32'(e && !c));
    check("c_yp", 32'(yc_p), 32'(ec_p));
    check("c_ym", 32'(yc_m), 32'(ec_m));
    check("c_vld", 32'(vc), 32'(e && !c));
  endtask

  initial begin
    RST = 1'b1; en = 1'b0; clr = 1'b0;
    clear_images();
    drive_x();
    model_reset();
    @(posedge CLK);
    #1;
    check_all_zero("reset_state");
    RST = 1'b0;

    // Max: element 3 of window (0,0) constant +1; first sample selects element 0
    pa[1][1] = 1;
    for (int n = 1; n <= 10; n++) begin
      step(1'b1, 1'b0);
      check("max_basic_sel", 32'(ya_p[0]), 32'(n != 1));
      check("max_basic_others", 32'(ya_p[3:1]), 32'd0);
    end

    // Tie and saturation: elements 0 and 1 both +1, counters pin at 7
    clear_images();
    step(1'b1, 1'b1);
    pa[0][0] = 1; pa[1][0] = 1;
    for (int n = 0; n < 20; n++) begin
      step(1'b1, 1'b0);
      check("tie_sel0", 32'(ya_p[0]), 32'd1);
    end
    pa[0][0] = 0; ma[0][0] = 1;
    step(1'b1, 1'b0);
    check("tie_last_el0", 32'({ya_p[0], ya_m[0]}), 32'b01);
    pa[0][0] = 1; ma[0][0] = 0; pa[1][0] = 0;
    step(1'b1, 1'b0);
    check("sat_follow_el1", 32'({ya_p[0], ya_m[0]}), 32'b00);

    // Average: all four elements -1 gives y_m every sample
    clear_images();
    step(1'b1, 1'b1);
    ma[0][0] = 1; ma[1][0] = 1; ma[0][1] = 1; ma[1][1] = 1;
    for (int n = 0; n < 6; n++) begin
      step(1'b1, 1'b0);
      check("avg_neg", 32'({yb_p[0], yb_m[0]}), 32'b01);
    end

    // Average with en gaps: pulse phase counts accepted samples only
    clear_images();
    step(1'b1, 1'b1);
    pa[1][1] = 1;
    for (int n = 1; n <= 2; n++) begin
      step(1'b1, 1'b0);
      check("avg_gap_pre", 32'(yb_p[0]), 32'd0);
    end
    for (int n = 0; n < 3; n++) begin
      step(1'b0, 1'b0);
      check_all_zero("en_low");
    end
    for (int n = 3; n <= 9; n++) begin
      step(1'b1, 1'b0);
      check("avg_gap_post", 32'(yb_p[0]), 32'((n % 4) == 0));
    end
    step(1'b1, 1'b1);
    check_all_zero("clr_with_en");
    for (int n = 1; n <= 5; n++) begin
      step(1'b1, 1'b0);
      check("avg_after_clr", 32'(yb_p[0]), 32'(n == 4));
    end

    // Padding: only pixel (0,0)=+1 feeds four of the nine padded windows
    clear_images();
    step(1'b1, 1'b1);
    pc[0][0] = 1;
    for (int n = 1; n <= 8; n++) begin
      step(1'b1, 1'b0);
      check("pad_yp", 32'(yc_p), ((n % 4) == 0) ? 32'h1B : 32'h0);
      check("pad_ym", 32'(yc_m), 32'h0);
    end

    // Randomized traffic with occasional stalls and clears
    for (int n = 0; n < 400; n++) begin
      random_images();
      step($urandom_range(0, 9) != 0, $urandom_range(0, 29) == 0);
    end

    // Asynchronous reset mid-stream, inputs keep toggling
    random_images();
    drive_x();
    en = 1'b1; clr = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    #1;
    check_all_zero("rst_async");
    for (int n = 0; n < 2; n++) begin
      random_images();
      drive_x();
      @(posedge CLK);
      #1;
      check_all_zero("rst_held");
    end
    RST = 1'b0;
    model_reset();
    random_images();
    step(1'b1, 1'b0);
    check("rst_first_sel0", 32'(ya_p[0]), 32'(pa[0][0] != 0));
    for (int n = 0; n < 50; n++) begin
      random_images();
      step($urandom_range(0, 7) != 0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stoch_signed_pool2d.md
# stoch_signed_pool2d

Parametrised stochastic signed 2-D pooling layer for bipolar (p/m split) bitstreams. It generalises the fixed max-pool to arbitrary image size, channels, kernel, stride and zero padding, with a compile-time mode select between max and average pooling. A run-time enable allows stalling, and a synchronous clear restarts all per-window state between images. It sits between a stochastic conv layer and the next layer in the NNlib stochastic datapath.

## Interface
- IM_HEIGHT, 4, input rows per channel
- IM_WIDTH, 4, input columns per channel
- CHANNELS, 1, channel count
- KERNEL_H / KERNEL_W, 2 / 2, window size
- STRIDE_H / STRIDE_W, 2 / 2, window step
- PAD_H / PAD_W, 0 / 0, zero padding per side
- COUNTER_SIZE, 8, signed counter width in max mode (≥3)
- MODE, 0, 0 = max pool, 1 = average pool
- Derived: K = KERNEL_H*KERNEL_W; OUT_H = floor((IM_HEIGHT+2*PAD_H-KERNEL_H)/STRIDE_H)+1; OUT_W likewise.

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  asynchronous, active-high reset
- en  in  1  a bitstream sample is present on x_p/x_m this cycle
- clr  in  1  synchronous clear of all window state
- x_p, x_m  in  CHANNELS*IM_HEIGHT*IM_WIDTH  positive/negative input bits
- y_p, y_m  out  CHANNELS*OUT_H*OUT_W  positive/negative output bits, registered
- y_valid  out  1  y_p/y_m hold a sample

## Operation
- Flat index, column-major: pixel (c,h,w) is bit c*IM_HEIGHT*IM_WIDTH + w*IM_HEIGHT + h. Output (c,oh,ow) is bit c*OUT_H*OUT_W + ow*OUT_H + oh.
- Window (c,oh,ow), element (kh,kw) maps to padded pixel (oh*STRIDE_H+kh-PAD_H, ow*STRIDE_W+kw-PAD_W). Out-of-image positions read as x_p=x_m=0. Element index i = kw*KERNEL_H + kh.
- Per-element signed value d_i = x_p_i - x_m_i ∈ {-1,0,+1}. x_p=x_m=1 gives 0.
- MODE 0 (max), per window:
  - K signed counters cnt_i, COUNTER_SIZE bits.
  - sel is the argmax of cnt before update. The lowest index wins ties.
  - On en: y_p ← x_p_sel, y_m ← x_m_sel, then cnt_i ← sat(cnt_i + d_i).
  - Saturation bounds are ±(2^(COUNTER_SIZE-1)-1). A counter at its bound that receives a same-sign step holds.
- MODE 1 (average), per window:
  - One signed accumulator acc, width clog2(K)+2.
  - On en: s = Σd_i and a = acc + s.
    - If a ≥ K: y_p←1, y_m←0, acc←a-K.
    - Else if a ≤ -K: y_p←0, y_m←1, acc←a+K.
    - Otherwise y_p=y_m=0 and acc←a.
  - Invariant: |acc| < K. The output never has y_p=y_m=1.
- en=0: all counters and accumulators hold. y_p, y_m and y_valid are driven to 0 next cycle.
- clr=1: counters, accumulators, y_p, y_m and y_valid all go to 0 next cycle. sel is effectively index 0. clr has priority over en, and the en sample in that cycle is discarded.
- Only the selected MODE's logic is generated.

## Timing
- RST asserted (async): y_p=0, y_m=0, y_valid=0, all cnt=0, all acc=0, held while RST=1.
- Latency is 1 cycle: a sample with en at edge n appears on y at edge n, readable in cycle n+1. y_valid is en delayed by one cycle (0 after clr/RST).
- Max mode: the sample at edge n is selected by counters reflecting samples < n. The first sample after reset/clr always selects element 0.
- Throughput is one sample per cycle, with no internal stall.
- Asserting RST mid-stream loses all state. The first en after release behaves as after clr.

## Test plan
- Reset: RST pulse mid-stream with inputs toggling -> y_p=y_m=y_valid=0 immediately; first en after release yields y_valid=1 next cycle and max-mode sel=0.
- Max, 4x4/2x2/stride 2: window(0,0) element 3 constant +1, others 0, en=1 for 10 cycles -> output 0 (0,0) y_p=0 on sample 1 (sel 0), y_p=1 on samples 2-10. Other windows stay 0.
- Max tie/saturation, COUNTER_SIZE=4: elements 0 and 1 both +1 for 20 cycles -> sel stays 0 and both counters saturate at 7. Then element 1 gets +1 and element 0 gets -1 for 1 cycle -> next sample follows element 1.
- Average, K=4: one element +1, three 0 -> y_p=1 on samples 4, 8, 12 only. All four -1 -> y_m=1 every sample.
- Padding, 2x2 image, 2x2 kernel, PAD 1, stride 1 (3x3 out): only pixel (0,0)=+1 in average mode -> outputs (0,0), (0,1), (1,0), (1,1) each produce y_p=1 every 4th sample; the remaining five outputs stay 0.
- clr/en: in average mode, drop en for 3 cycles mid-stream -> outputs 0 and pulse phase resumes unchanged. Assert clr together with en -> next cycle all 0 with y_valid=0, and the pulse count restarts (first pulse on 4th subsequent sample).
